// File: rtl/mannix_pkg.sv
// Shared types and requantisation helper for the dot-product datapath.
// Signed accumulate, rounding shift, ReLU, unsigned saturate.
package mannix_pkg;

  localparam int DP_W    = 32;
  localparam int ACC_W   = 32;
  localparam int OUT_W   = 8;
  localparam int LEN_W   = 8;
  localparam int SHIFT_W = 5;
  localparam int ACT_MAX = 255;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_RUN,
    ACC_HOLD
  } state_t;

  // One extra bit keeps the rounding add from overflowing.
  function automatic logic [OUT_W-1:0] requant(
    input logic [ACC_W-1:0]   s,
    input logic [SHIFT_W-1:0] sh
  );
    logic        [ACC_W:0] rnd;
    logic signed [ACC_W:0] x;
    logic signed [ACC_W:0] r;
    rnd = '0;
    if (sh != '0)
      rnd = (ACC_W+1)'(1) << (sh - SHIFT_W'(1));
    x = $signed({s[ACC_W-1], s}) + $signed(rnd);
    r = x >>> sh;
    if (r[ACC_W])
      return '0;
    if (r > $signed((ACC_W+1)'(ACT_MAX)))
      return OUT_W'(ACT_MAX);
    return r[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/requant_relu_sat.sv
// Combinational requantiser: rounding arithmetic shift,
// ReLU and saturation to an unsigned activation.
module requant_relu_sat
  import mannix_pkg::*;
(
  input  logic [ACC_W-1:0]   s,
  input  logic [SHIFT_W-1:0] shift,
  output logic [OUT_W-1:0]   act
);

  assign act = requant(s, shift);

endmodule

// File: rtl/dp_acc_requant.sv
// Accumulates cfg_len partial dot products, adds bias and
// requantises into a held unsigned activation.
module dp_acc_requant
  import mannix_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DP_W-1:0]    in_data,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [ACC_W-1:0]   cfg_bias,
  input  logic [SHIFT_W-1:0] cfg_shift,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic [ACC_W-1:0]   out_acc,
  output logic               busy
);

  state_t             st;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   bias_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt;
  logic [SHIFT_W-1:0] sh_q;

  logic               idle;
  logic               take;
  logic               last;
  logic [ACC_W-1:0]   acc_nxt;
  logic [ACC_W-1:0]   bias_e;
  logic [ACC_W-1:0]   s;
  logic [LEN_W-1:0]   len_e;
  logic [LEN_W-1:0]   cnt_nxt;
  logic [SHIFT_W-1:0] sh_e;
  logic [OUT_W-1:0]   act;

  assign idle     = (st == ACC_IDLE);
  assign in_ready = !rst && (st != ACC_HOLD);
  assign busy     = !idle;
  assign take     = in_valid && in_ready;

  // In IDLE the live config is used; afterwards the shadow copy.
  assign len_e   = idle ? ((cfg_len == '0) ? LEN_W'(1) : cfg_len)
                        : len_q;
  assign bias_e  = idle ? cfg_bias : bias_q;
  assign sh_e    = idle ? cfg_shift : sh_q;
  assign acc_nxt = (idle ? '0 : acc) + in_data;
  assign cnt_nxt = idle ? LEN_W'(1) : cnt + LEN_W'(1);
  assign last    = (cnt_nxt == len_e);
  assign s       = acc_nxt + bias_e;

  requant_relu_sat u_rq (
    .s     (s),
    .shift (sh_e),
    .act   (act)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= ACC_IDLE;
      acc       <= '0;
      cnt       <= '0;
      len_q     <= '0;
      bias_q    <= '0;
      sh_q      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_acc   <= '0;
    end else begin
      unique case (st)
        ACC_IDLE, ACC_RUN: begin
          if (take) begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
            if (idle) begin
              len_q  <= len_e;
              bias_q <= cfg_bias;
              sh_q   <= cfg_shift;
            end
            if (last) begin
              out_data  <= act;
              out_acc   <= s;
              out_valid <= 1'b1;
              st        <= ACC_HOLD;
            end else begin
              st <= ACC_RUN;
            end
          end
        end
        ACC_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            st        <= ACC_IDLE;
          end
        end
        default: st <= ACC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dp_acc_requant.sv
// Self-checking bench for dp_acc_requant: vector table,
// scoreboard queue and hand-written backpressure/reset cases.
module tb_dp_acc_requant;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [7:0]  cfg_len;
  logic [31:0] cfg_bias;
  logic [4:0]  cfg_shift;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [31:0] out_acc;
  logic        busy;

  int nchk = 0;
  int nerr = 0;

  typedef struct {
    int len, bias, sh, n;
    int p0, p1, p2, p3;
    int ed, ea;
  } vec_t;

  typedef struct {
    int d;
    int a;
  } exp_t;

  vec_t tbl[11];
  exp_t q[$];

  dp_acc_requant dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .cfg_len   (cfg_len),
    .cfg_bias  (cfg_bias),
    .cfg_shift (cfg_shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_acc   (out_acc),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard: pop on every output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_data", int'(out_data), e.d);
        chk("sb_acc", $signed(out_acc), e.a);
      end
    end
  end

  task automatic set_vec(input int i, input int len, input int bias,
                         input int sh, input int n,
                         input int p0, input int p1,
                         input int p2, input int p3,
                         input int ed, input int ea);
    tbl[i].len = len; tbl[i].bias = bias; tbl[i].sh = sh;
    tbl[i].n = n;
    tbl[i].p0 = p0; tbl[i].p1 = p1; tbl[i].p2 = p2; tbl[i].p3 = p3;
    tbl[i].ed = ed; tbl[i].ea = ea;
  endtask

  task automatic push(input int d, input int a);
    exp_t e;
    e.d = d;
    e.a = a;
    q.push_back(e);
  endtask

  // Entered and left at posedge+1.
  task automatic send_beat(input int d);
    int t;
    bit ok;
    in_valid = 1'b1;
    in_data  = d;
    t  = 0;
    ok = 1'b0;
    while (!ok && t < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    in_valid = 1'b0;
    if (!ok) chk("beat_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic run_vec(input vec_t v);
    int pv[4];
    pv = '{v.p0, v.p1, v.p2, v.p3};
    cfg_len   = 8'(v.len);
    cfg_bias  = v.bias;
    cfg_shift = 5'(v.sh);
    push(v.ed, v.ea);
    for (int k = 0; k < v.n; k++) begin
      send_beat(pv[k]);
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk);
        #1;
      end
    end
    wait_drain();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    cfg_len   = '0;
    cfg_bias  = '0;
    cfg_shift = '0;
    out_ready = 1'b1;

    set_vec(0, 4, 0, 0, 4, 10, 20, 30, 40, 100, 100);
    set_vec(1, 2, 1, 2, 2, 300, 300, 0, 0, 150, 601);
    set_vec(2, 1, 0, 0, 1, -5000, 0, 0, 0, 0, -5000);
    set_vec(3, 1, 0, 4, 1, 70000, 0, 0, 0, 255, 70000);
    set_vec(4, 0, 0, 0, 1, 7, 0, 0, 0, 7, 7);
    set_vec(5, 3, -10, 1, 3, 5, 6, 7, 0, 4, 8);
    set_vec(6, 1, 0, 2, 1, 6, 0, 0, 0, 2, 6);
    set_vec(7, 1, 0, 0, 1, 256, 0, 0, 0, 255, 256);
    set_vec(8, 1, 0, 31, 1, 32'h7fffffff, 0, 0, 0, 1, 32'h7fffffff);
    set_vec(9, 2, 0, 0, 2, 32'h7fffffff, 1, 0, 0, 0, 32'h80000000);
    set_vec(10, 1, 0, 1, 1, -3, 0, 0, 0, 0, -3);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_acc", $signed(out_acc), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_in_ready", int'(in_ready), 1);

    for (int i = 0; i < 11; i++) run_vec(tbl[i]);

    // Backpressure with input gaps, then handshake racing new input.
    cfg_len   = 8'd3;
    cfg_bias  = '0;
    cfg_shift = '0;
    out_ready = 1'b0;
    push(60, 60);
    send_beat(10);
    @(posedge clk);
    #1;
    send_beat(20);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("stall_no_out", int'(out_valid), 0);
    send_beat(30);
    chk("latency_valid", int'(out_valid), 1);
    cfg_len  = 8'd1;
    in_valid = 1'b1;
    in_data  = 5;
    push(5, 5);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_data", int'(out_data), 60);
      chk("hold_acc", $signed(out_acc), 60);
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_busy", int'(busy), 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_valid", int'(out_valid), 0);
    chk("release_busy", int'(busy), 0);
    chk("release_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("fresh_valid", int'(out_valid), 1);
    chk("fresh_data", int'(out_data), 5);
    wait_drain();

    // Config changes after the first beat must be ignored.
    cfg_len   = 8'd3;
    cfg_bias  = '0;
    cfg_shift = '0;
    push(6, 6);
    send_beat(1);
    cfg_bias  = 1000;
    cfg_len   = 8'd1;
    cfg_shift = 5'd3;
    send_beat(2);
    send_beat(3);
    wait_drain();

    // Asynchronous reset mid-accumulation.
    cfg_len   = 8'd4;
    cfg_bias  = '0;
    cfg_shift = '0;
    send_beat(1);
    send_beat(2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_in_ready", int'(in_ready), 0);
    chk("arst_out_data", int'(out_data), 0);
    chk("arst_out_acc", $signed(out_acc), 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_busy", int'(busy), 0);
    cfg_len = 8'd2;
    push(3, 3);
    send_beat(1);
    send_beat(2);
    wait_drain();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/dp_acc_requant.md
Name: dp_acc_requant

Overview:
- Downstream stage of the parallel dot-product array.
- Consumes one signed 32-bit partial dot product per valid/ready beat and accumulates cfg_len partials into one output-channel sum.
- Adds a per-channel bias, then requantises: rounding arithmetic right shift, ReLU, saturation to an unsigned 8-bit activation.
- Presents the result on a registered valid/ready output, ready to feed the next layer's unsigned activation input.

Parameters:
- DP_W, 32, width of the incoming partial dot product (signed).
- ACC_W, 32, accumulator and bias width (signed, two's-complement wrap).
- OUT_W, 8, output activation width (unsigned).
- LEN_W, 8, width of cfg_len.
- SHIFT_W, 5, width of cfg_shift.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  partial sum valid.
- in_ready  out  1  stage can accept a partial sum.
- in_data  in  DP_W  signed partial dot product.
- cfg_len  in  LEN_W  partials per output; 0 is treated as 1.
- cfg_bias  in  ACC_W  signed bias.
- cfg_shift  in  SHIFT_W  requantisation right-shift, 0..31.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  OUT_W  requantised unsigned activation.
- out_acc  out  ACC_W  raw acc+bias before shift (debug/verification).
- busy  out  1  high in ACC or HOLD.

Behaviour:
- Reset (async, rst=1): state=IDLE, acc=0, cnt=0, out_valid=0, out_data=0, out_acc=0, busy=0, in_ready=0 while rst asserted.
- in_ready=1 in IDLE and ACC; 0 in HOLD.
- A beat is accepted when in_valid&&in_ready.
- FSM states:
  - IDLE: on accepted beat, latch cfg_len (0->1), cfg_bias and cfg_shift into shadow registers; acc=in_data; cnt=1. If latched len==1, go directly to the finish step, else go to ACC.
  - ACC: on accepted beat, acc=acc+in_data (ACC_W wrap, no saturation); cnt++. When cnt reaches len on that beat, do the finish step.
  - Finish step (same edge as the last accepted beat):
    - s = acc_next + bias (wrap).
    - r = (s + (shift?1<<(shift-1):0)) >>> shift, computed at ACC_W+1 bits so the rounding add cannot overflow.
    - out_data = (r<0)?0 : (r>2^OUT_W-1)?2^OUT_W-1 : r.
    - out_acc = s; out_valid=1; state=HOLD.
  - HOLD: in_ready=0. On out_valid&&out_ready: out_valid=0, acc=0, cnt=0, state=IDLE. out_data and out_acc stay stable while out_valid=1 and !out_ready.
- Latency: out_valid rises on the clk edge after the last beat is accepted (1 cycle).
- Throughput: len+1 cycles per output with out_ready held high.
- Config changes mid-accumulation are ignored; the shadow copies are used.
- in_valid low during ACC is a stall; acc and cnt hold.
- cfg_shift=0: no rounding term; r=s.
- Reset asserted mid-accumulation or in HOLD discards the partial sum and any pending output; after release the block is in IDLE with out_valid=0.
- Simultaneous out handshake and new in_valid in HOLD: the input is not accepted that cycle (in_ready=0). It is accepted in IDLE the next cycle.

Decomposition:
- Shared package (mannix_pkg):
  - FSM state enum: ACC_IDLE, ACC_RUN, ACC_HOLD.
  - Localparams: DP_W=32, ACC_W=32, OUT_W=8, ACT_MAX=255.
  - Requant function signature: rounding shift + ReLU + saturate.
- One natural sub-module: requant_relu_sat, combinational.
  - Inputs: s[ACC_W], shift[SHIFT_W]. Output: act[OUT_W].
  - Instantiated once; reused later in the pooling path.

Test Plan:
- Basic: cfg_len=4, bias=0, shift=0, partials 10,20,30,40 back-to-back -> out_valid 1 cycle after 4th beat; out_data=100, out_acc=100; in_ready=0 until out_ready.
- Rounding/shift: len=2, partials 300,300, bias=1, shift=2 -> s=601, r=(601+2)>>>2=150; out_data=150, out_acc=601.
- ReLU/saturation, two runs:
  - len=1, partial -5000, bias=0 -> out_data=0, out_acc=-5000.
  - len=1, partial 70000, shift=4 -> r=4375 -> out_data=255.
- Backpressure/stall: len=3 with in_valid gaps; out_ready low 5 cycles.
  - out_data/out_acc stable and in_ready=0 throughout.
  - After out_ready=1: IDLE, and the next accepted beat starts a fresh acc (no residue).
- Config isolation & len=0: cfg_len=0, partial 7 -> out_data=7.
  - Then len=3; change cfg_bias from 0 to 1000 after the first beat -> result uses bias 0.
- Reset mid-operation: assert rst after 2 of 4 beats -> all outputs 0 immediately (async).
  - Then a fresh len=2 run of 1,2 -> out_data=3.
